skinny_sbox8_ti3_pipe: RTL and testbench

- Parametrised successor of the 3-share threshold-implementation SKINNY 8-bit S-box.
- Processes LANES S-boxes in parallel through a 4-stage register pipeline, with valid/ready handshakes on both sides and asynchronous reset.
- The input no longer needs to be held stable for 4 cycles.
- Sits between the shared state register and ShiftRows in the masked round datapath.

---
 rtl/skinny_ti_pkg.sv | 50 +++++
 rtl/skinny_sbox8_ti3_pipe_chi.sv | 31 +++
 rtl/skinny_sbox8_ti3_pipe.sv | 111 +++++++++++
 tb/tb_skinny_sbox8_ti3_pipe.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/skinny_ti_pkg.sv
// Shared constants for the 3-share threshold SKINNY 8-bit S-box pipeline.
// S8_TAB / s8_ref is the unmasked reference table, used by benches only.
package skinny_ti_pkg;

   localparam int unsigned SHARES      = 3;
   localparam int unsigned SBOX_STAGES = 4;

   // OBIT[k] is the output bit position that carries intermediate a_k
   localparam int unsigned OBIT [8] = '{6, 5, 2, 7, 3, 1, 4, 0};

   localparam logic [7:0] S8_TAB [256] = '{
      8'h65, 8'h4c, 8'h6a, 8'h42, 8'h4b, 8'h63, 8'h43, 8'h6b,
      8'h55, 8'h75, 8'h5a, 8'h7a, 8'h53, 8'h73, 8'h5b, 8'h7b,
      8'h35, 8'h8c, 8'h3a, 8'h81, 8'h89, 8'h33, 8'h80, 8'h3b,
      8'h95, 8'h25, 8'h98, 8'h2a, 8'h90, 8'h23, 8'h99, 8'h2b,
      8'he5, 8'hcc, 8'he8, 8'hc1, 8'hc9, 8'he0, 8'hc0, 8'he9,
      8'hd5, 8'hf5, 8'hd8, 8'hf8, 8'hd0, 8'hf0, 8'hd9, 8'hf9,
      8'ha5, 8'h1c, 8'ha8, 8'h12, 8'h1b, 8'ha0, 8'h13, 8'ha9,
      8'h05, 8'hb5, 8'h0a, 8'hb8, 8'h03, 8'hb0, 8'h0b, 8'hb9,
      8'h32, 8'h88, 8'h3c, 8'h85, 8'h8d, 8'h34, 8'h84, 8'h3d,
      8'h91, 8'h22, 8'h9c, 8'h2c, 8'h94, 8'h24, 8'h9d, 8'h2d,
      8'h62, 8'h4a, 8'h6c, 8'h45, 8'h4d, 8'h64, 8'h44, 8'h6d,
      8'h52, 8'h72, 8'h5c, 8'h7c, 8'h54, 8'h74, 8'h5d, 8'h7d,
      8'ha1, 8'h1a, 8'hac, 8'h15, 8'h1d, 8'ha4, 8'h14, 8'had,
      8'h02, 8'hb1, 8'h0c, 8'hbc, 8'h04, 8'hb4, 8'h0d, 8'hbd,
      8'he1, 8'hc8, 8'hec, 8'hc5, 8'hcd, 8'he4, 8'hc4, 8'hed,
      8'hd1, 8'hf1, 8'hdc, 8'hfc, 8'hd4, 8'hf4, 8'hdd, 8'hfd,
      8'h36, 8'h8e, 8'h38, 8'h82, 8'h8b, 8'h30, 8'h83, 8'h39,
      8'h96, 8'h26, 8'h9a, 8'h28, 8'h93, 8'h20, 8'h9b, 8'h29,
      8'h66, 8'h4e, 8'h68, 8'h41, 8'h49, 8'h60, 8'h40, 8'h69,
      8'h56, 8'h76, 8'h58, 8'h78, 8'h50, 8'h70, 8'h59, 8'h79,
      8'ha6, 8'h1e, 8'haa, 8'h11, 8'h19, 8'ha3, 8'h10, 8'hab,
      8'h06, 8'hb6, 8'h08, 8'hba, 8'h00, 8'hb3, 8'h09, 8'hbb,
      8'he6, 8'hce, 8'hea, 8'hc2, 8'hcb, 8'he3, 8'hc3, 8'heb,
      8'hd6, 8'hf6, 8'hda, 8'hfa, 8'hd3, 8'hf3, 8'hdb, 8'hfb,
      8'h31, 8'h8a, 8'h3e, 8'h86, 8'h8f, 8'h37, 8'h87, 8'h3f,
      8'h92, 8'h21, 8'h9e, 8'h2e, 8'h97, 8'h27, 8'h9f, 8'h2f,
      8'h61, 8'h48, 8'h6e, 8'h46, 8'h4f, 8'h67, 8'h47, 8'h6f,
      8'h51, 8'h71, 8'h5e, 8'h7e, 8'h57, 8'h77, 8'h5f, 8'h7f,
      8'ha2, 8'h18, 8'hae, 8'h16, 8'h1f, 8'ha7, 8'h17, 8'haf,
      8'h01, 8'hb2, 8'h0e, 8'hbe, 8'h07, 8'hb7, 8'h0f, 8'hbf,
      8'he2, 8'hca, 8'hee, 8'hc6, 8'hcf, 8'he7, 8'hc7, 8'hef,
      8'hd2, 8'hf2, 8'hde, 8'hfe, 8'hd7, 8'hf7, 8'hdf, 8'hff
   };

   function automatic logic [7:0] s8_ref(input logic [7:0] x);
      return S8_TAB[x];
   endfunction

endpackage

// File: rtl/skinny_sbox8_ti3_pipe_chi.sv
// One 3-share f = NOR(a,b) ^ z; share 0 of a and b is inverted so the
// AND of the complements is a non-complete sharing. Output is registered.
module ti3_chi_stage
   import skinny_ti_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              en_i,
   input  logic [SHARES-1:0] a_i,
   input  logic [SHARES-1:0] b_i,
   input  logic [SHARES-1:0] z_i,
   output logic [SHARES-1:0] f_o
);

   logic [SHARES-1:0] x, y, f_d, f_q;

   assign x = {a_i[2:1], ~a_i[0]};
   assign y = {b_i[2:1], ~b_i[0]};

   assign f_d[0] = (x[1] & y[1]) ^ (x[1] & y[2]) ^ (x[2] & y[1]) ^ z_i[0];
   assign f_d[1] = (x[2] & y[2]) ^ (x[0] & y[2]) ^ (x[2] & y[0]) ^ z_i[1];
   assign f_d[2] = (x[0] & y[0]) ^ (x[0] & y[1]) ^ (x[1] & y[0]) ^ z_i[2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) f_q <= '0;
      else if (en_i) f_q <= f_d;
   end

   assign f_o = f_q;

endmodule

// File: rtl/skinny_sbox8_ti3_pipe.sv
// LANES parallel 3-share SKINNY-128 8-bit S-boxes in a 4-stage pipeline
// with valid/ready on both sides and a single global advance.
module skinny_sbox8_ti3_pipe
   import skinny_ti_pkg::*;
#(
   parameter int unsigned LANES = 1,
   parameter bit          PIPE  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [8*LANES-1:0] si0,
   input  logic [8*LANES-1:0] si1,
   input  logic [8*LANES-1:0] si2,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [8*LANES-1:0] bo0,
   output logic [8*LANES-1:0] bo1,
   output logic [8*LANES-1:0] bo2
);

   logic [SBOX_STAGES-1:0] v_q, v_d;
   logic                   adv;

   assign adv       = ~v_q[SBOX_STAGES-1] | out_ready;
   assign out_valid = v_q[SBOX_STAGES-1];
   assign in_ready  = PIPE ? adv : (adv & ~|v_q);
   assign v_d       = {v_q[SBOX_STAGES-2:0], in_valid & in_ready};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) v_q <= '0;
      else if (adv) v_q <= v_d;
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [SHARES-1:0] b [8];
      logic [SHARES-1:0] a [8];
      logic [SHARES-1:0] o [8];
      logic [SHARES-1:0] b5_1_q, b1_1_q, b7_1_q, b3_1_q, b2_1_q;
      logic [SHARES-1:0] b7_2_q, b3_2_q, b2_2_q, b2_3_q;
      // d2/d3/d4: a_k carried forward so all eight leave stage 4 together
      logic [SHARES-1:0] d2_q [3];
      logic [SHARES-1:0] d3_q [5];
      logic [SHARES-1:0] d4_q [7];

      for (genvar k = 0; k < 8; k++) begin : g_bit
         assign b[k] = {si2[8*l+k], si1[8*l+k], si0[8*l+k]};
         assign bo0[8*l+OBIT[k]] = o[k][0];
         assign bo1[8*l+OBIT[k]] = o[k][1];
         assign bo2[8*l+OBIT[k]] = o[k][2];
         if (k < 7) begin : g_dly
            assign o[k] = d4_q[k];
         end else begin : g_chi
            assign o[k] = a[7];
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            b5_1_q <= '0;
            b1_1_q <= '0;
            b7_1_q <= '0;
            b3_1_q <= '0;
            b2_1_q <= '0;
            b7_2_q <= '0;
            b3_2_q <= '0;
            b2_2_q <= '0;
            b2_3_q <= '0;
            for (int k = 0; k < 3; k++) d2_q[k] <= '0;
            for (int k = 0; k < 5; k++) d3_q[k] <= '0;
            for (int k = 0; k < 7; k++) d4_q[k] <= '0;
         end else if (adv) begin
            b5_1_q <= b[5];
            b1_1_q <= b[1];
            b7_1_q <= b[7];
            b3_1_q <= b[3];
            b2_1_q <= b[2];
            b7_2_q <= b7_1_q;
            b3_2_q <= b3_1_q;
            b2_2_q <= b2_1_q;
            b2_3_q <= b2_2_q;
            for (int k = 0; k < 3; k++) d2_q[k] <= a[k];
            for (int k = 0; k < 3; k++) d3_q[k] <= d2_q[k];
            d3_q[3] <= a[3];
            d3_q[4] <= a[4];
            for (int k = 0; k < 5; k++) d4_q[k] <= d3_q[k];
            d4_q[5] <= a[5];
            d4_q[6] <= a[6];
         end
      end

      ti3_chi_stage u_a0 (.clk, .rst, .en_i(adv), .a_i(b[7]),
         .b_i(b[6]), .z_i(b[4]), .f_o(a[0]));
      ti3_chi_stage u_a1 (.clk, .rst, .en_i(adv), .a_i(b[3]),
         .b_i(b[2]), .z_i(b[0]), .f_o(a[1]));
      ti3_chi_stage u_a2 (.clk, .rst, .en_i(adv), .a_i(b[2]),
         .b_i(b[1]), .z_i(b[6]), .f_o(a[2]));
      ti3_chi_stage u_a3 (.clk, .rst, .en_i(adv), .a_i(a[0]),
         .b_i(a[1]), .z_i(b5_1_q), .f_o(a[3]));
      ti3_chi_stage u_a4 (.clk, .rst, .en_i(adv), .a_i(a[1]),
         .b_i(b3_1_q), .z_i(b1_1_q), .f_o(a[4]));
      ti3_chi_stage u_a5 (.clk, .rst, .en_i(adv), .a_i(d2_q[2]),
         .b_i(a[3]), .z_i(b7_2_q), .f_o(a[5]));
      ti3_chi_stage u_a6 (.clk, .rst, .en_i(adv), .a_i(a[3]),
         .b_i(d2_q[0]), .z_i(b3_2_q), .f_o(a[6]));
      ti3_chi_stage u_a7 (.clk, .rst, .en_i(adv), .a_i(d3_q[4]),
         .b_i(a[5]), .z_i(b2_3_q), .f_o(a[7]));
   end

endmodule

// File: tb/tb_skinny_sbox8_ti3_pipe.sv
// Bench for skinny_sbox8_ti3_pipe: a 4-lane streaming instance and a
// 1-lane non-pipelined instance, both checked against the S8 table.
module tb_skinny_sbox8_ti3_pipe;
   import skinny_ti_pkg::*;

   typedef struct {
      logic [31:0] e;
      int          acc;
   } item_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        a_iv, a_ir, a_ov, a_or;
   logic [31:0] a_s0, a_s1, a_s2, a_b0, a_b1, a_b2;
   logic        b_iv, b_ir, b_ov, b_or;
   logic [7:0]  b_s0, b_s1, b_s2, b_o0, b_o1, b_o2;

   int    n_tests = 0;
   int    n_fail  = 0;
   int    cyc     = 0;
   int    b_last  = -1;
   bit    chk_lat = 1'b1;
   item_t a_q [$];
   item_t b_q [$];
   logic [31:0] last_x;
   logic [7:0]  last_0, last_1, last_2;
   logic [31:0] snap0, snap1, snap2;
   logic [7:0]  v0 [3];
   logic [7:0]  v1 [3];
   logic [7:0]  v2 [3];

   always #5 clk = ~clk;

   skinny_sbox8_ti3_pipe #(.LANES(4), .PIPE(1'b1)) dut (
      .clk(clk), .rst(rst),
      .in_valid(a_iv), .in_ready(a_ir),
      .si0(a_s0), .si1(a_s1), .si2(a_s2),
      .out_valid(a_ov), .out_ready(a_or),
      .bo0(a_b0), .bo1(a_b1), .bo2(a_b2)
   );

   skinny_sbox8_ti3_pipe #(.LANES(1), .PIPE(1'b0)) dut_np (
      .clk(clk), .rst(rst),
      .in_valid(b_iv), .in_ready(b_ir),
      .si0(b_s0), .si1(b_s1), .si2(b_s2),
      .out_valid(b_ov), .out_ready(b_or),
      .bo0(b_o0), .bo1(b_o1), .bo2(b_o2)
   );

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] x);
      logic [31:0] r;
      logic [7:0]  t;
      r = '0;
      for (int l = 0; l < 4; l++) begin
         t = x[8*l +: 8];
         r[8*l +: 8] = s8_ref(t);
      end
      return r;
   endfunction

   task automatic split_a(input logic [31:0] x);
      a_s0 = $urandom;
      a_s1 = $urandom;
      a_s2 = x ^ a_s0 ^ a_s1;
   endtask

   // Sample at the falling edge, run the scoreboards, then step one cycle.
   task automatic tick();
      item_t       it;
      logic [31:0] xa;
      @(negedge clk);
      xa = a_b0 ^ a_b1 ^ a_b2;
      if (a_q.size() > 0 && chk_lat && cyc - a_q[0].acc == 4)
         chk("a_valid_at_4", 64'(a_ov), 64'(1));
      if (a_q.size() == 0) chk("a_idle_valid", 64'(a_ov), 64'(0));
      else if (a_ov && a_or) begin
         it = a_q.pop_front();
         chk("a_data", 64'(xa), 64'(it.e));
         if (chk_lat) chk("a_latency", 64'(cyc - it.acc), 64'(4));
         last_x = xa;
         last_0 = a_b0[7:0];
         last_1 = a_b1[7:0];
         last_2 = a_b2[7:0];
      end
      if (a_iv && a_ir) begin
         it.e = model(a_s0 ^ a_s1 ^ a_s2);
         it.acc = cyc;
         a_q.push_back(it);
      end
      chk("b_in_ready", 64'(b_ir), 64'(b_q.size() == 0));
      if (b_q.size() == 0) chk("b_idle_valid", 64'(b_ov), 64'(0));
      else if (b_ov && b_or) begin
         it = b_q.pop_front();
         chk("b_data", 64'(b_o0 ^ b_o1 ^ b_o2), 64'(it.e));
         chk("b_latency", 64'(cyc - it.acc), 64'(4));
      end
      if (b_iv && b_ir) begin
         if (b_last >= 0) chk("b_accept_gap", 64'(cyc - b_last >= 4), 64'(1));
         b_last = cyc;
         it.e = 32'(s8_ref(b_s0 ^ b_s1 ^ b_s2));
         it.acc = cyc;
         b_q.push_back(it);
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      a_iv = 1'b0; a_or = 1'b1; a_s0 = '0; a_s1 = '0; a_s2 = '0;
      b_iv = 1'b0; b_or = 1'b1; b_s0 = '0; b_s1 = '0; b_s2 = '0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_out_valid", 64'({a_ov, b_ov}), 64'(0));
      chk("rst_bo", 64'({a_b0, a_b1, a_b2}), 64'(0));
      chk("rst_bo_np", 64'({b_o0, b_o1, b_o2}), 64'(0));
      rst = 1'b0;
      chk("post_rst_ready", 64'({a_ir, b_ir}), 64'(2'b11));

      // single items, all-zero shares then 0xA5/0xA5/0xFF
      a_iv = 1'b1;
      tick();
      a_iv = 1'b0;
      repeat (5) tick();
      chk("zero_in", 64'(last_x), 64'(32'h65656565));
      a_s0 = 32'hA5A5A5A5; a_s1 = 32'hA5A5A5A5; a_s2 = 32'hFFFFFFFF;
      a_iv = 1'b1;
      tick();
      a_iv = 1'b0;
      repeat (5) tick();
      chk("ff_in", 64'(last_x), 64'(32'hFFFFFFFF));

      // exhaustive back-to-back streaming across 4 lanes
      for (int i = 0; i < 64; i++) begin
         logic [31:0] x;
         for (int k = 0; k < 4; k++) x[8*k +: 8] = 8'(4*i + k);
         split_a(x);
         a_iv = 1'b1;
         chk("stream_ready", 64'(a_ir), 64'(1));
         tick();
      end
      a_iv = 1'b0;
      repeat (6) tick();
      chk("stream_drained", 64'(a_q.size()), 64'(0));

      // backpressure with 4 items in flight
      for (int i = 0; i < 4; i++) begin
         split_a($urandom);
         a_iv = 1'b1;
         tick();
      end
      a_or = 1'b0;
      chk_lat = 1'b0;
      snap0 = a_b0; snap1 = a_b1; snap2 = a_b2;
      chk("bp_valid", 64'(a_ov), 64'(1));
      for (int i = 0; i < 6; i++) begin
         split_a($urandom);
         tick();
         chk("bp_in_ready", 64'(a_ir), 64'(0));
         chk("bp_valid_hold", 64'(a_ov), 64'(1));
         chk("bp_frozen", 64'(a_b0 ^ snap0 | a_b1 ^ snap1 | a_b2 ^ snap2), 64'(0));
      end
      a_iv = 1'b0;
      a_or = 1'b1;
      repeat (8) tick();
      chk_lat = 1'b1;
      chk("bp_drained", 64'(a_q.size()), 64'(0));

      // non-pipelined instance with in_valid held high
      b_iv = 1'b1;
      for (int i = 0; i < 30; i++) begin
         b_s0 = 8'($urandom);
         b_s1 = 8'($urandom);
         b_s2 = 8'($urandom);
         tick();
      end
      b_iv = 1'b0;
      repeat (6) tick();
      chk("np_drained", 64'(b_q.size()), 64'(0));
      chk("np_accepted", 64'(b_last > 20), 64'(1));

      // asynchronous reset with one item stalled at the output
      split_a($urandom);
      a_iv = 1'b1;
      tick();
      a_iv = 1'b0;
      tick();
      tick();
      split_a(32'h00000001);
      a_iv = 1'b1;
      tick();
      a_iv = 1'b0;
      a_or = 1'b0;
      chk_lat = 1'b0;
      tick();
      tick();
      #2;
      chk("pre_rst_valid", 64'(a_ov), 64'(1));
      rst = 1'b1;
      #1;
      chk("async_rst_valid", 64'({a_ov, b_ov}), 64'(0));
      chk("async_rst_bo", 64'({a_b0, a_b1, a_b2}), 64'(0));
      a_q.delete();
      b_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      a_or = 1'b1;
      chk_lat = 1'b1;
      chk("rst_release_ready", 64'({a_ir, b_ir}), 64'(2'b11));
      repeat (8) tick();

      // same value 0x02 under three random splits
      for (int j = 0; j < 3; j++) begin
         split_a({8'($urandom), 8'($urandom), 8'($urandom), 8'h02});
         a_iv = 1'b1;
         tick();
         a_iv = 1'b0;
         repeat (5) tick();
         chk("split_02", 64'(last_x[7:0]), 64'(8'h6A));
         v0[j] = last_0;
         v1[j] = last_1;
         v2[j] = last_2;
      end
      chk("share0_varies", 64'(v0[0] == v0[1] && v0[1] == v0[2]), 64'(0));
      chk("share1_varies", 64'(v1[0] == v1[1] && v1[1] == v1[2]), 64'(0));
      chk("share2_varies", 64'(v2[0] == v2[1] && v2[1] == v2[2]), 64'(0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
